// File: rtl/hit_judge_pkg.sv
// Shared types for the beat hit judge: grade codes, FSM states, saturating helper.
package hit_judge_pkg;

  typedef enum logic [1:0] {
    GRADE_MISS    = 2'd0,
    GRADE_GOOD    = 2'd1,
    GRADE_PERFECT = 2'd2,
    GRADE_WRONG   = 2'd3
  } grade_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    DONE   = 2'd2,
    CLOSED = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Player/metronome inputs and grading outputs of hit_judge.
// HIT_JUDGE_STATS_EN adds the per-grade statistics counters.
interface hit_judge_if #(
  parameter int NUM_LANES  = 4,
  parameter int COMBO_BITS = 8
);
  logic                  enable;
  logic                  beat;
  logic [NUM_LANES-1:0]  arrow;
  logic [NUM_LANES-1:0]  btn;
  logic                  grade_valid;
  hit_judge_pkg::grade_t grade;
  logic                  partial;
  logic [COMBO_BITS-1:0] combo;
  logic [COMBO_BITS-1:0] max_combo;
`ifdef HIT_JUDGE_STATS_EN
  logic [15:0]           n_perfect, n_good, n_miss, n_wrong;
`endif

  modport slave (
    input  enable, beat, arrow, btn,
`ifdef HIT_JUDGE_STATS_EN
    output n_perfect, n_good, n_miss, n_wrong,
`endif
    output grade_valid, grade, partial, combo, max_combo
  );

  modport master (
    output enable, beat, arrow, btn,
`ifdef HIT_JUDGE_STATS_EN
    input  n_perfect, n_good, n_miss, n_wrong,
`endif
    input  grade_valid, grade, partial, combo, max_combo
  );
endinterface

// File: rtl/hit_judge_edge_sync.sv
// 2-flop synchroniser plus registered rise/fall pulses; pulses land 3 clk after the input edge.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[1:0], din};
      rise <= sh[1] & ~sh[2];
      fall <= ~sh[1] & sh[2];
    end
  end
endmodule

// File: rtl/hit_judge.sv
// Grades button presses against the expected lane mask per beat window and tracks combos.
// Define HIT_JUDGE_STATS_EN to add per-grade saturating statistics counters.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int          NUM_LANES   = 4,
  parameter int          CNT_BITS    = 24,
  parameter int unsigned PERFECT_CYC = 2500000,
  parameter int          COMBO_BITS  = 8
) (
  input logic        clk,
  input logic        rst,
  hit_judge_if.slave bus
);
  logic [NUM_LANES-1:0] press;
  logic                 beat_rise, beat_fall;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_btn
    edge_sync u_sync (.clk(clk), .rst(rst), .din(bus.btn[i]), .rise(press[i]), .fall());
  end
  edge_sync u_beat (.clk(clk), .rst(rst), .din(bus.beat), .rise(beat_rise), .fall(beat_fall));

  state_t                state, state_n;
  logic [NUM_LANES-1:0]  expected, expected_n, pressed, pressed_n;
  logic [NUM_LANES-1:0]  exp_eff, got_eff;
  logic [CNT_BITS-1:0]   cnt, cnt_n, cnt_eff;
  logic                  wrong_used, wrong_used_n;
  logic                  opening, issue;
  grade_t                grade_n;
  logic [COMBO_BITS-1:0] combo_n;

  // A window opening this cycle is judged immediately, so a coincident press lands at cnt=0.
  assign opening = beat_rise && (state == CLOSED || state == DONE);
  assign exp_eff = opening ? bus.arrow : expected;
  assign got_eff = opening ? '0 : pressed;
  assign cnt_eff = opening ? '0 : cnt;

  always_comb begin
    state_n      = state;
    expected_n   = expected;
    pressed_n    = pressed;
    cnt_n        = cnt;
    wrong_used_n = wrong_used;
    issue        = 1'b0;
    grade_n      = GRADE_MISS;
    if (!bus.enable) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      state_n      = CLOSED;
      wrong_used_n = 1'b0;
    end else if (opening || state == OPEN) begin
      state_n    = OPEN;
      expected_n = exp_eff;
      pressed_n  = got_eff | press;
      cnt_n      = opening ? '0 : ((&cnt) ? cnt : cnt + CNT_BITS'(1));
      if (opening) wrong_used_n = 1'b0;
      if ((press & ~exp_eff) != '0 || (press & got_eff) != '0) begin
        issue   = 1'b1;
        grade_n = GRADE_WRONG;
        state_n = DONE;
      end else if (pressed_n == exp_eff && exp_eff != '0) begin
        issue   = 1'b1;
        grade_n = (32'(cnt_eff) < PERFECT_CYC) ? GRADE_PERFECT : GRADE_GOOD;
        state_n = DONE;
      end else if (beat_fall && !opening) begin
        issue   = (exp_eff != '0);
        grade_n = GRADE_MISS;
        state_n = CLOSED;
      end
    end else if (state == DONE) begin
      if (beat_fall) state_n = CLOSED;
    end else if (press != '0 && !wrong_used) begin
      issue        = 1'b1;
      grade_n      = GRADE_WRONG;
      wrong_used_n = 1'b1;
    end
  end

  always_comb begin
    combo_n = '0;
    if (grade_n == GRADE_PERFECT || grade_n == GRADE_GOOD)
      combo_n = (&bus.combo) ? bus.combo : bus.combo + COMBO_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      expected        <= '0;
      pressed         <= '0;
      cnt             <= '0;
      wrong_used      <= 1'b0;
      bus.grade_valid <= 1'b0;
      bus.grade       <= GRADE_MISS;
      bus.combo       <= '0;
      bus.max_combo   <= '0;
    end else begin
      state           <= state_n;
      expected        <= expected_n;
      pressed         <= pressed_n;
      cnt             <= cnt_n;
      wrong_used      <= wrong_used_n;
      bus.grade_valid <= issue;
      if (issue) begin
        bus.grade <= grade_n;
        bus.combo <= combo_n;
        if (combo_n > bus.max_combo) bus.max_combo <= combo_n;
      end
    end
  end

  assign bus.partial = (state == OPEN) && (pressed != '0) && (pressed != expected);

`ifdef HIT_JUDGE_STATS_EN
  logic en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q          <= 1'b0;
      bus.n_perfect <= '0;
      bus.n_good    <= '0;
      bus.n_miss    <= '0;
      bus.n_wrong   <= '0;
    end else begin
      en_q <= bus.enable;
      if (bus.enable && !en_q) begin
        bus.n_perfect <= '0;
        bus.n_good    <= '0;
        bus.n_miss    <= '0;
        bus.n_wrong   <= '0;
      end else if (issue) begin
        case (grade_n)
          GRADE_PERFECT: bus.n_perfect <= sat_inc16(bus.n_perfect);
          GRADE_GOOD:    bus.n_good    <= sat_inc16(bus.n_good);
          GRADE_MISS:    bus.n_miss    <= sat_inc16(bus.n_miss);
          default:       bus.n_wrong   <= sat_inc16(bus.n_wrong);
        endcase
      end
    end
  end
`endif

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Parametrised successor of the per-beat hit checker. Judges player button presses against an expected lane mask on each beat window.
- Generalised to NUM_LANES lanes with any combination of lanes per beat.
- Grades each beat as PERFECT, GOOD, MISS or WRONG using a cycle-accurate timing window, and keeps a combo count.
- Sits between the button inputs / metronome and the score/display logic; active only while the game is running.

Parameters:
- NUM_LANES, 4: number of buttons/lanes; expected mask and button bus width.
- CNT_BITS, 24: width of the in-window cycle counter.
- PERFECT_CYC, 2500000: a hit completed with cnt < PERFECT_CYC grades PERFECT.
- COMBO_BITS, 8: width of combo and max_combo.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  high while the game state is active
- beat  in  1  metronome level, async; high = hit window open
- arrow  in  NUM_LANES  expected lane mask; sampled at window open
- btn  in  NUM_LANES  raw async buttons, active-high
- grade_valid  out  1  one-cycle pulse when a grade is issued
- grade  out  2  0=MISS, 1=GOOD, 2=PERFECT, 3=WRONG; valid with grade_valid
- partial  out  1  high while the pressed set is a non-empty strict subset of the expected set
- combo  out  COMBO_BITS  current consecutive-hit count
- max_combo  out  COMBO_BITS  highest combo since reset

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs, counters and latches 0.
- Input conditioning:
  - Each btn bit and beat pass through a 2-flop synchroniser plus rising-edge detect.
  - press[i] pulses 3 clk after the btn[i] rise.
  - beat rise/fall pulses use the same 3-cycle latency, so window timing and presses stay aligned.
- States: IDLE, OPEN, DONE, CLOSED.
  - IDLE -> CLOSED when enable=1.
  - Any state -> IDLE when enable=0. Any in-progress window is aborted with no grade; combo is held.
- beat rise, from CLOSED or DONE:
  - expected <= arrow; pressed <= 0; cnt <= 0; state <= OPEN.
- OPEN, each cycle:
  - cnt increments, saturating at all-ones.
  - On any press: if (press & ~expected) != 0, or (press & pressed) != 0 (lane repeated), issue WRONG and go to DONE.
  - Otherwise pressed <= pressed | press.
  - If the new pressed == expected (and expected != 0), issue PERFECT when cnt < PERFECT_CYC, else GOOD, and go to DONE.
  - Lanes pressed in the same cycle count together (chords).
- beat fall:
  - In OPEN with expected != 0: issue MISS.
  - In OPEN with expected == 0 and nothing pressed: no grade (empty beat).
  - Then go to CLOSED.
  - In DONE: go to CLOSED silently.
- CLOSED: any press issues WRONG. At most one WRONG per closed interval; further presses are ignored until the next beat rise.
- Simultaneous events:
  - beat rise and press in the same cycle: the press counts in the new window at cnt=0.
  - beat fall and a completing press in the same cycle: the press is evaluated first, so a hit is graded and no MISS is issued.
- partial: combinational from the registered pressed/expected; forced 0 outside OPEN.
- Combo:
  - PERFECT/GOOD: combo +1, saturating at all-ones.
  - MISS/WRONG: combo <= 0.
  - max_combo <= max(max_combo, new combo) in the same cycle.
- Grade latency: grade_valid asserts 1 cycle after the deciding press/beat pulse. Never more than one grade per cycle.

Optional Feature:
- Macro: HIT_JUDGE_STATS_EN.
- Defined: adds output ports n_perfect, n_good, n_miss, n_wrong, each 16 bits.
  - Each saturating counter increments on the matching grade_valid.
  - Counters clear on rst and on an enable rise.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hit_judge_pkg holds:
  - grade encodings GRADE_MISS/GOOD/PERFECT/WRONG;
  - the state encoding IDLE/OPEN/DONE/CLOSED;
  - the 2-bit grade type.
- Sub-module edge_sync: 2-flop synchroniser + rising/falling pulse, with clk and rst.
  - Instantiated NUM_LANES times for btn and once for beat.

Test Plan:
- PERFECT_CYC=8, arrow=4'b0001; beat rise, btn[0] rise 2 clk after beat rise -> grade=PERFECT, combo 0->1.
- arrow=4'b0011; btn[0] at cnt=3, btn[1] at cnt=12 -> partial=1 between the two presses, then grade=GOOD, combo +1.
- arrow=4'b0101, btn[1] pressed in window -> grade=WRONG, combo=0; max_combo keeps its prior value (e.g. 2).
- arrow=4'b0010, no press, beat falls -> grade=MISS. Repeat with arrow=0 and no press -> no grade_valid, combo unchanged.
- Press btn[2] twice while beat low -> exactly one WRONG pulse.
  - Assert rst mid-OPEN -> all outputs 0 immediately.
  - Drop enable mid-OPEN -> no grade, combo held.
- Combo at 255, another PERFECT -> combo stays 255.
  - With HIT_JUDGE_STATS_EN, grades P,G,M,W -> each n_* counter equals 1.
